// File: rtl/alu_sequencer.sv
// Runs 8-bit ADD/SUB/AND/OR/XOR on an external 4-bit ALU as two nibble passes (low, then high).
// The carry is chained between passes. The result and flags stay held under a valid/ready handshake.
module alu_sequencer (
    input  logic       CLK100MHZ,
    input  logic       reset,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [3:0] req_opcode,
    input  logic [7:0] req_A,
    input  logic [7:0] req_B,
    output logic       res_valid,
    input  logic       res_ready,
    output logic [7:0] res_data,
    output logic       res_c_out,
    output logic       res_ovf,
    output logic       res_err,
    output logic [3:0] alu_A,
    output logic [3:0] alu_B,
    output logic [2:0] alu_op,
    output logic       alu_mode,
    output logic       alu_c_in,
    input  logic [3:0] alu_out,
    input  logic       alu_c_out
);

    // Handshake: a request transfers on an edge where req_valid && req_ready.
    // A result transfers on an edge where res_valid && res_ready.
    typedef enum logic [1:0] {S_IDLE, S_LO, S_HI, S_DONE} state_t;

    state_t     state_q, state_d;
    logic [3:0] op_q, op_d;
    logic [7:0] a_q, a_d, b_q, b_d;
    logic [7:0] res_data_q, res_data_d;
    logic       res_c_q, res_c_d, res_ovf_q, res_ovf_d, res_err_q, res_err_d;
    logic [3:0] alu_a_q, alu_a_d, alu_b_q, alu_b_d;
    logic [2:0] alu_op_q, alu_op_d;
    logic       alu_mode_q, alu_mode_d, alu_c_in_q, alu_c_in_d;
    logic       arith;

    // Per-opcode ALU controls for the low pass: {op[2:0], mode, c_in}.
    function automatic logic [4:0] lo_ctrl(input logic [3:0] op);
        case (op)
            4'd1:    lo_ctrl = {3'b000, 1'b1, 1'b1};
            4'd2:    lo_ctrl = {3'b001, 1'b0, 1'b0};
            4'd3:    lo_ctrl = {3'b010, 1'b0, 1'b0};
            4'd4:    lo_ctrl = {3'b011, 1'b0, 1'b0};
            default: lo_ctrl = 5'b00000;
        endcase
    endfunction

    assign arith = (op_q == 4'd0) || (op_q == 4'd1);

    always_ff @(posedge CLK100MHZ or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            op_q       <= 4'd0;
            a_q        <= 8'd0;
            b_q        <= 8'd0;
            res_data_q <= 8'd0;
            res_c_q    <= 1'b0;
            res_ovf_q  <= 1'b0;
            res_err_q  <= 1'b0;
            alu_a_q    <= 4'd0;
            alu_b_q    <= 4'd0;
            alu_op_q   <= 3'd0;
            alu_mode_q <= 1'b0;
            alu_c_in_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            a_q        <= a_d;
            b_q        <= b_d;
            res_data_q <= res_data_d;
            res_c_q    <= res_c_d;
            res_ovf_q  <= res_ovf_d;
            res_err_q  <= res_err_d;
            alu_a_q    <= alu_a_d;
            alu_b_q    <= alu_b_d;
            alu_op_q   <= alu_op_d;
            alu_mode_q <= alu_mode_d;
            alu_c_in_q <= alu_c_in_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (req_valid) state_d = (req_opcode <= 4'd4) ? S_LO : S_DONE;
            S_LO:   state_d = S_HI;
            S_HI:   state_d = S_DONE;
            S_DONE: if (res_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // ALU drive is registered: each state's nibble operands are loaded on the edge that enters it.
    always_comb begin
        op_d       = op_q;
        a_d        = a_q;
        b_d        = b_q;
        res_data_d = res_data_q;
        res_c_d    = res_c_q;
        res_ovf_d  = res_ovf_q;
        res_err_d  = res_err_q;
        alu_a_d    = 4'd0;
        alu_b_d    = 4'd0;
        alu_op_d   = 3'd0;
        alu_mode_d = 1'b0;
        alu_c_in_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    op_d       = req_opcode;
                    a_d        = req_A;
                    b_d        = req_B;
                    res_data_d = 8'd0;
                    res_c_d    = 1'b0;
                    res_ovf_d  = 1'b0;
                    res_err_d  = (req_opcode > 4'd4);
                    if (req_opcode <= 4'd4) begin
                        alu_a_d = req_A[3:0];
                        alu_b_d = req_B[3:0];
                        {alu_op_d, alu_mode_d, alu_c_in_d} = lo_ctrl(req_opcode);
                    end
                end
            end
            S_LO: begin
                res_data_d[3:0] = alu_out;
                alu_a_d         = a_q[7:4];
                alu_b_d         = b_q[7:4];
                alu_op_d        = alu_op_q;
                alu_mode_d      = alu_mode_q;
                alu_c_in_d      = arith ? alu_c_out : 1'b0;
            end
            S_HI: begin
                res_data_d[7:4] = alu_out;
                res_c_d         = arith ? alu_c_out : 1'b0;
                if (op_q == 4'd0)
                    res_ovf_d = (a_q[7] == b_q[7]) && (alu_out[3] != a_q[7]);
                else if (op_q == 4'd1)
                    res_ovf_d = (a_q[7] != b_q[7]) && (alu_out[3] != a_q[7]);
                else
                    res_ovf_d = 1'b0;
            end
            default: ;
        endcase
    end

    assign req_ready = (state_q == S_IDLE);
    assign res_valid = (state_q == S_DONE);
    assign res_data  = res_data_q;
    assign res_c_out = res_c_q;
    assign res_ovf   = res_ovf_q;
    assign res_err   = res_err_q;
    assign alu_A     = alu_a_q;
    assign alu_B     = alu_b_q;
    assign alu_op    = alu_op_q;
    assign alu_mode  = alu_mode_q;
    assign alu_c_in  = alu_c_in_q;

endmodule
